serial_adder_ctrl: RTL and testbench
====================================

Name: serial_adder_ctrl

Overview:
Bit-serial sequencer that wraps the team's 1-bit full adder cell (the SUMATOR cell, with operand inputs in1/in2, carry-in in3, sum out1 and carry-out out6). It feeds one operand bit pair and the registered carry to the cell each clock. It then collects the sum bit and carry-out the cell returns. Together they form a WIDTH-bit ripple-in-time adder with a start/done handshake toward the datapath controller.

Parameters:
WIDTH, 8, operand and sum width in bits (legal range 1..32)
CNT_W, $clog2(WIDTH+1), bit-counter width (derived; not overridden)

Ports:
clk  input  1  single clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
op_a  input  WIDTH  operand A; captured on accepted start
op_b  input  WIDTH  operand B; captured on accepted start
cin  input  1  initial carry; captured on accepted start
fa_a  output  1  to full-adder in1: current A bit (LSB first)
fa_b  output  1  to full-adder in2: current B bit
fa_cin  output  1  to full-adder in3: registered carry
fa_sum  input  1  from full-adder out1
fa_cout  input  1  from full-adder out6
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse; result valid
sum  output  WIDTH  result; holds until next accepted start
cout  output  1  final carry; holds until next accepted start

Behaviour:
- Reset (async, rst_n=0): state=IDLE; a_sr, b_sr, sum_sr, carry_q, count all 0. Outputs: busy=0, done=0, sum=0, cout=0, fa_a=fa_b=fa_cin=0. Takes effect immediately, including mid-RUN; the partial result is discarded and no done is issued.
- States: IDLE, RUN, DONE (encoding per the shared package).
- IDLE: if start=1 at an edge, then a_sr<=op_a, b_sr<=op_b, carry_q<=cin, count<=0, state<=RUN. Otherwise hold. start=0 leaves everything unchanged.
- RUN, combinational drive: fa_a=a_sr[0], fa_b=b_sr[0], fa_cin=carry_q.
- RUN, each edge:
  - sum_sr<={fa_sum, sum_sr[WIDTH-1:1]}
  - carry_q<=fa_cout
  - a_sr, b_sr shift right with 0 fill
  - count<=count+1
  - when count==WIDTH-1 at the edge, state<=DONE
- DONE: done=1 for exactly one cycle. sum=sum_sr and cout=carry_q are valid from this cycle on. Next edge returns to IDLE unconditionally.
- Latency: start accepted at edge 0. WIDTH RUN cycles complete at edges 1..WIDTH. done is high in the cycle after edge WIDTH. The next start can be accepted at edge WIDTH+2 at the earliest.
- start asserted while busy=1 is ignored; it is not queued.
- op_a/op_b/cin changes after acceptance have no effect.
- fa_* outputs are driven to 0 outside RUN. The full adder's combinational settle time must fit in one clk period; fa_sum/fa_cout are sampled only in RUN.
- Arithmetic: {cout,sum} = op_a + op_b + cin, modulo 2^(WIDTH+1). No overflow flag.
- WIDTH=1: RUN lasts exactly one cycle.

Decomposition:
- Shared package serial_adder_pkg: state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and WIDTH default constant.
- One natural sub-module: sreg_piso, a parameterised right-shift register with parallel load. Instantiate it twice for a_sr and b_sr. sum_sr stays inline as a SIPO.
- The full adder remains an external cell, connected at the parent level. The bench uses a behavioural full-adder model in its place.

Test Plan:
- WIDTH=8, op_a=5, op_b=3, cin=0, start pulse -> done exactly 9 cycles after the accepting edge; sum=8'h08, cout=0; fa_a sequence LSB-first 1,0,1,0,0,0,0,0.
- op_a=8'hFF, op_b=8'h01, cin=0 -> sum=8'h00, cout=1; fa_cin high on bits 1..7.
- op_a=0, op_b=0, cin=1 -> sum=8'h01, cout=0. Then op_a=8'hFF, op_b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- start held high continuously with changing operands -> only the operands present at each accepted edge are used; results return every WIDTH+2 cycles; no start is accepted while busy=1.
- rst_n pulsed low asynchronously at count=4 -> busy, done, sum and cout go to 0 immediately; no done pulse follows. The next start runs a clean 9-cycle addition.
- WIDTH=1, op_a=1, op_b=1, cin=1 -> sum=1, cout=1, done in the cycle after edge 1.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder sequencer: FSM state encoding
// and the default operand width.
package serial_adder_pkg;

    localparam int WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_adder_ctrl_sreg_piso.sv
// Parallel-in serial-out right-shift register; the LSB is presented on sout
// and zeros are shifted in from the top.
module sreg_piso #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             sout
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    // A logical shift keeps the WIDTH=1 case legal without a part-select.
    always_comb begin
        sr_d = sr_q;
        if (load) begin
            sr_d = din;
        end else if (shift) begin
            sr_d = sr_q >> 1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign sout = sr_q[0];

endmodule

// File: rtl/serial_adder_ctrl.sv
// WIDTH-bit ripple-in-time adder: streams operand bits LSB first through an
// external 1-bit full-adder cell and gathers the sum with a start/done handshake.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q,   sum_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;

    logic             op_load;
    logic             op_shift;
    logic             a_bit;
    logic             b_bit;

    sreg_piso #(.WIDTH(WIDTH)) u_a_sr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (op_load),
        .shift (op_shift),
        .din   (op_a),
        .sout  (a_bit)
    );

    sreg_piso #(.WIDTH(WIDTH)) u_b_sr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (op_load),
        .shift (op_shift),
        .din   (op_b),
        .sout  (b_bit)
    );

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        carry_d  = carry_q;
        sum_d    = sum_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        op_load  = 1'b0;
        op_shift = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_load = 1'b1;
                    carry_d = cin;
                    count_d = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end

            RUN: begin
                // Sum bits enter at the MSB so bit 0 lands in place after WIDTH shifts.
                op_shift = 1'b1;
                sum_d    = (sum_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
                carry_d  = fa_cout;
                count_d  = count_q + CNT_W'(1);
                if (count_q == LAST_BIT) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end

            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // The cell only sees live operands while RUN; elsewhere it idles at zero.
    assign fa_a   = (state_q == RUN) && a_bit;
    assign fa_b   = (state_q == RUN) && b_bit;
    assign fa_cin = (state_q == RUN) && carry_q;

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = carry_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl at WIDTH=8 and WIDTH=1, each wired to a
// behavioural full adder, with a queue of expected {cout,sum} results.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic clk;
    logic rst_n;

    logic         start, cin, fa_a, fa_b, fa_cin, fa_sum, fa_cout, busy, done, cout;
    logic [W-1:0] op_a, op_b, sum;

    logic         start1, cin1, fa_a1, fa_b1, fa_cin1, fa_sum1, fa_cout1, busy1, done1, cout1;
    logic [0:0]   op_a1, op_b1, sum1;

    int checks;
    int errors;

    logic [W:0] exp_q[$];
    logic [1:0] exp1_q[$];

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b), .cin(cin),
        .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin), .fa_sum(fa_sum), .fa_cout(fa_cout),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .op_a(op_a1), .op_b(op_b1), .cin(cin1),
        .fa_a(fa_a1), .fa_b(fa_b1), .fa_cin(fa_cin1), .fa_sum(fa_sum1), .fa_cout(fa_cout1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    assign fa_sum   = fa_a ^ fa_b ^ fa_cin;
    assign fa_cout  = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);
    assign fa_sum1  = fa_a1 ^ fa_b1 ^ fa_cin1;
    assign fa_cout1 = (fa_a1 & fa_b1) | (fa_a1 & fa_cin1) | (fa_b1 & fa_cin1);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    function automatic logic [W:0] model_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        return (W+1)'(a) + (W+1)'(b) + (W+1)'(c);
    endfunction

    function automatic logic [W-1:0] model_carries(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        logic [W-1:0] cv;
        logic cy;
        cy = c;
        for (int i = 0; i < W; i++) begin
            cv[i] = cy;
            cy = (a[i] & b[i]) | (a[i] & cy) | (b[i] & cy);
        end
        return cv;
    endfunction

    // Drives a one-cycle start at a falling edge, returns one falling edge after acceptance.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        cin   = c;
        exp_q.push_back(model_add(a, b, c));
        @(negedge clk);
        start = 1'b0;
        op_a  = W'($urandom);
        op_b  = W'($urandom);
        cin   = 1'($urandom);
    endtask

    task automatic wait_done(output int n, output bit to);
        n  = 0;
        to = 1'b0;
        while (done !== 1'b1) begin
            if (n >= 40) begin
                to = 1'b1;
                break;
            end
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0; op_a = '0; op_b = '0; cin = 1'b0;
        start1 = 1'b0; op_a1 = '0; op_b1 = '0; cin1 = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, cout, sum, fa_a, fa_b, fa_cin} !== '0) begin
            errors++;
            $display("FAIL reset_w8: busy=%b done=%b cout=%b sum=%h fa=%b%b%b, want all 0",
                     busy, done, cout, sum, fa_a, fa_b, fa_cin);
        end
        checks++;
        if ({busy1, done1, cout1, sum1, fa_a1, fa_b1, fa_cin1} !== '0) begin
            errors++;
            $display("FAIL reset_w1: busy=%b done=%b cout=%b sum=%b, want all 0", busy1, done1, cout1, sum1);
        end
        rst_n = 1'b1;
        op_a = 8'hA5; op_b = 8'h3C; cin = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, cout, sum} !== '0) begin
            errors++;
            $display("FAIL idle_hold: busy=%b done=%b cout=%b sum=%h, want all 0 without start",
                     busy, done, cout, sum);
        end
    endtask

    task automatic test_basic();
        logic [W-1:0] a_seq;
        logic [W:0]   e;
        bit           early;
        early = 1'b0;
        issue(8'd5, 8'd3, 1'b0);
        for (int n = 0; n < W; n++) begin
            a_seq[n] = fa_a;
            if (done !== 1'b0) early = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (early) begin
            errors++;
            $display("FAIL basic_early_done: done seen before cycle %0d", W);
        end
        checks++;
        if (a_seq !== 8'd5) begin
            errors++;
            $display("FAIL basic_fa_a_seq: got %b (LSB first), want %b", a_seq, 8'd5);
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_done_timing: done=%b busy=%b after edge %0d, want 1 1", done, busy, W);
        end
        e = exp_q.pop_front();
        checks++;
        if ({cout, sum} !== e) begin
            errors++;
            $display("FAIL basic_result: got cout=%b sum=%h, want cout=%b sum=%h", cout, sum, e[W], e[W-1:0]);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || {cout, sum} !== e) begin
            errors++;
            $display("FAIL basic_after_done: done=%b busy=%b sum=%h, want 0 0 %h", done, busy, sum, e[W-1:0]);
        end
    endtask

    task automatic test_carry_chain();
        logic [W-1:0] cin_seq, b_seq, exp_c;
        logic [W:0]   e;
        int n;
        bit to;
        exp_c = model_carries(8'hFF, 8'h01, 1'b0);
        issue(8'hFF, 8'h01, 1'b0);
        for (int i = 0; i < W; i++) begin
            cin_seq[i] = fa_cin;
            b_seq[i]   = fa_b;
            @(negedge clk);
        end
        checks++;
        if (cin_seq !== exp_c) begin
            errors++;
            $display("FAIL carry_fa_cin_seq: got %b, want %b", cin_seq, exp_c);
        end
        checks++;
        if (b_seq !== 8'h01) begin
            errors++;
            $display("FAIL carry_fa_b_seq: got %b, want %b", b_seq, 8'h01);
        end
        wait_done(n, to);
        e = exp_q.pop_front();
        checks++;
        if (to || {cout, sum} !== e) begin
            errors++;
            $display("FAIL carry_result: timeout=%b cout=%b sum=%h, want cout=%b sum=%h", to, cout, sum, e[W], e[W-1:0]);
        end
        @(negedge clk);
    endtask

    task automatic test_cin_cases();
        logic [W-1:0] a_tab[2] = '{8'h00, 8'hFF};
        logic [W-1:0] b_tab[2] = '{8'h00, 8'hFF};
        logic [W:0]   e;
        int n;
        bit to;
        for (int k = 0; k < 2; k++) begin
            issue(a_tab[k], b_tab[k], 1'b1);
            wait_done(n, to);
            checks++;
            if (to || n != W) begin
                errors++;
                $display("FAIL cin_latency_%0d: got %0d cycles timeout=%b, want %0d", k, n, to, W);
            end
            e = exp_q.pop_front();
            checks++;
            if ({cout, sum} !== e) begin
                errors++;
                $display("FAIL cin_result_%0d: got cout=%b sum=%h, want cout=%b sum=%h", k, cout, sum, e[W], e[W-1:0]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [W:0] e;
        start = 1'b1;
        for (int c = 0; c < 30; c++) begin
            checks++;
            if (done !== (c % 10 == 9) || busy !== (c % 10 != 0)) begin
                errors++;
                $display("FAIL b2b_handshake_c%0d: done=%b busy=%b, want %b %b",
                         c, done, busy, (c % 10 == 9), (c % 10 != 0));
            end
            if (c % 10 == 9) begin
                e = exp_q.pop_front();
                checks++;
                if ({cout, sum} !== e) begin
                    errors++;
                    $display("FAIL b2b_result_c%0d: got cout=%b sum=%h, want cout=%b sum=%h",
                             c, cout, sum, e[W], e[W-1:0]);
                end
            end
            op_a = W'($urandom);
            op_b = W'($urandom);
            cin  = 1'($urandom);
            if (c % 10 == 0) exp_q.push_back(model_add(op_a, op_b, cin));
            @(negedge clk);
        end
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_drain: busy=%b pending=%0d, want 0 0", busy, exp_q.size());
        end
    endtask

    task automatic test_async_reset();
        logic [W:0] e;
        bit seen;
        int n;
        bit to;
        issue(8'h6B, 8'h2D, 1'b1);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        checks++;
        if ({busy, done, cout, sum, fa_a, fa_b, fa_cin} !== '0) begin
            errors++;
            $display("FAIL async_reset: busy=%b done=%b cout=%b sum=%h fa=%b%b%b, want all 0",
                     busy, done, cout, sum, fa_a, fa_b, fa_cin);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL async_no_done: done/busy seen after aborted run, want none");
        end
        issue(8'h9C, 8'h47, 1'b0);
        wait_done(n, to);
        checks++;
        if (to || n != W) begin
            errors++;
            $display("FAIL async_clean_latency: got %0d cycles timeout=%b, want %0d", n, to, W);
        end
        e = exp_q.pop_front();
        checks++;
        if ({cout, sum} !== e) begin
            errors++;
            $display("FAIL async_clean_result: got cout=%b sum=%h, want cout=%b sum=%h", cout, sum, e[W], e[W-1:0]);
        end
        @(negedge clk);
    endtask

    task automatic test_width1();
        logic [1:0] e;
        start1 = 1'b1; op_a1 = 1'b1; op_b1 = 1'b1; cin1 = 1'b1;
        exp1_q.push_back(2'(op_a1) + 2'(op_b1) + 2'(cin1));
        @(negedge clk);
        start1 = 1'b0; op_a1 = 1'b0; op_b1 = 1'b0; cin1 = 1'b0;
        checks++;
        if (done1 !== 1'b0 || busy1 !== 1'b1 || {fa_a1, fa_b1, fa_cin1} !== 3'b111) begin
            errors++;
            $display("FAIL w1_run: done=%b busy=%b fa=%b%b%b, want 0 1 111", done1, busy1, fa_a1, fa_b1, fa_cin1);
        end
        @(negedge clk);
        e = exp1_q.pop_front();
        checks++;
        if (done1 !== 1'b1 || {cout1, sum1} !== e) begin
            errors++;
            $display("FAIL w1_result: done=%b cout=%b sum=%b, want 1 %b %b", done1, cout1, sum1, e[1], e[0]);
        end
        @(negedge clk);
        checks++;
        if (done1 !== 1'b0 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL w1_after: done=%b busy=%b, want 0 0", done1, busy1);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_carry_chain();
        test_cin_cases();
        test_back_to_back();
        test_async_reset();
        test_width1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
